// File: rtl/tff_seq_pkg.sv
// Shared types for the T flip-flop sequencing controller: FSM states and
// count-direction constants.
package tff_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/tff_cell.sv
// Single T flip-flop: q flips on every rising edge where t is high.
module tff_cell (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q
);

    logic q_q;
    logic q_d;

    assign q_d = q_q ^ t;
    assign q   = q_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

endmodule

// File: rtl/tff_seq_ctrl.sv
// Start/limit/done sequencer driving a bank of T flip-flops as an up/down counter.
// Define TFF_SEQ_AUTORELOAD_EN to reload load_val at the limit instead of finishing.
module tff_seq_ctrl
    import tff_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] tog,
    output logic             busy,
    output logic             done,
    output logic             tc
);

    state_e           state_q, state_d;
    logic             dir_q, dir_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             step;
    logic             reload;
    logic [WIDTH-1:0] up_tog;
    logic [WIDTH-1:0] dn_tog;

    assign tc   = (count == limit);
    assign busy = busy_q;
    assign done = done_q;

    // Bit i toggles when every lower bit is 1 (up) or 0 (down).
    always_comb begin
        logic c_up;
        logic c_dn;
        c_up   = 1'b1;
        c_dn   = 1'b1;
        up_tog = '0;
        dn_tog = '0;
        for (int i = 0; i < WIDTH; i++) begin
            up_tog[i] = c_up;
            dn_tog[i] = c_dn;
            c_up      = c_up & count[i];
            c_dn      = c_dn & ~count[i];
        end
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        step    = 1'b0;
        reload  = 1'b0;
        tog     = '0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    dir_d   = dir;
                end
            end
            RUN: begin
                // A coincident load pre-empts termination; the limit is rechecked on the new value.
                if (stop) begin
                    state_d = IDLE;
                end else if (!load && tc) begin
`ifdef TFF_SEQ_AUTORELOAD_EN
                    reload = 1'b1;
                    done_d = 1'b1;
`else
                    state_d = DONE;
`endif
                end else if (!load) begin
                    step = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load || reload) begin
            tog = count ^ load_val;
        end else if (step) begin
            tog = (dir_q == DIR_DOWN) ? dn_tog : up_tog;
        end

        busy_d = (state_d == RUN);
        done_d = done_d | (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            dir_q   <= DIR_UP;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bank
        tff_cell u_cell (
            .clk (clk),
            .rst (rst),
            .t   (tog[i]),
            .q   (count[i])
        );
    end

endmodule

// File: doc/tff_seq_ctrl.md
# tff_seq_ctrl

Sequencing controller for a bank of WIDTH T flip-flops operated as a synchronous counter. Each cycle it computes the per-bit toggle vector that makes the bank count up or count down, load an arbitrary value, or hold. It also runs a start/limit/done handshake so a host block can launch a bounded count and wait for completion. The block sits between control logic and the T flip-flop bank; the bank itself is instantiated inside this block.

## Interface
- WIDTH, 8, counter / T flip-flop bank width (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  launch a count run; sampled only in IDLE
- stop  input  1  abort the run; RUN or DONE → IDLE
- dir  input  1  1 = up, 0 = down; latched when start is accepted
- load  input  1  force count ← load_val on the next edge
- load_val  input  WIDTH  value to load
- limit  input  WIDTH  terminal value for the run; sampled live
- count  output  WIDTH  T flip-flop bank state
- tog  output  WIDTH  toggle vector applied this cycle (debug)
- busy  output  1  state is RUN
- done  output  1  one-cycle completion pulse (state DONE)
- tc  output  1  combinational, count == limit

## Operation
- Reset (async): count=0, state=IDLE, latched dir=1. Outputs: busy=0, done=0, tog=0. tc reflects 0==limit.
- States: IDLE, RUN, DONE.
- IDLE: start=1 → RUN and latch dir. Otherwise stay in IDLE.
- RUN, stop=1 → IDLE.
- RUN, count==limit (without auto-reload) → DONE, count held.
- RUN, otherwise: stay in RUN and count ±1.
- DONE → IDLE unconditionally after one cycle. stop in DONE has the same result.
- Toggle vector, priority load > count > hold:
  - load: tog = count ^ load_val
  - up: tog[0]=1, tog[i] = &count[i-1:0]
  - down: tog[0]=1, tog[i] = &~count[i-1:0]
  - hold: tog=0
- Counting applies only in RUN when not terminating.
- load is honoured in every state and does not change the state. If load and the terminal condition coincide, the load wins and termination is evaluated on the new value next cycle.
- load and start in the same IDLE cycle: the load applies and the state enters RUN. The first count step uses the loaded value.
- stop and load in the same cycle: both take effect.
- start is ignored outside IDLE. dir changes during RUN are ignored.
- Wrap-around is modulo 2^WIDTH: up 0xFF→0x00, down 0x00→0xFF. The limit check is equality only.

## Timing
- start high at edge N (IDLE) → busy=1 after N. First count change at edge N+1.
- A run from value a to limit b (up) takes (b−a) mod 2^W count edges.
  - Then one edge RUN→DONE, with done high for exactly one cycle.
  - Then IDLE.
- If count==limit already at entry, the run takes zero counting cycles: DONE follows on the next edge.
- load latency is one edge. tc and tog are combinational from registered count and inputs.
- Async rst asserted mid-run clears everything immediately; done is not produced.

## Configuration
- TFF_SEQ_AUTORELOAD_EN defined: in RUN with count==limit and stop=0, the block stays in RUN. On that edge count ← load_val (toggle via load path) and done pulses for one cycle while busy stays 1. DONE is unreachable.
- Undefined: behaviour exactly as in Operation.

## Structure
- Shared package tff_seq_pkg:
  - state enum (IDLE, RUN, DONE)
  - direction constants (DIR_UP=1, DIR_DOWN=0)
- Sub-module tff_cell: one T flip-flop with async active-high rst, reset q=0, q ← q ^ t. Instantiated WIDTH times via generate.
- The controller holds the FSM, dir latch and toggle-vector logic. Count state lives only in the tff_cell instances.

## Test plan
- Reset: assert rst mid-cycle during RUN with count=0x35 → count=0x00, busy=0, done=0 immediately, without waiting for a clock edge.
- Up run: load 0x03, then start with dir=1, limit=0x07 → count steps 3,4,5,6,7. Then done=1 for one cycle, then IDLE with count=0x07.
- Down wrap: load 0x01, then start with dir=0, limit=0xFE → count steps 0x01,0x00,0xFF,0xFE. Then done. tog=0xFF on the 0x00→0xFF step.
- Load override: in RUN at count=0x10, pulse load with load_val=0x80 → count=0x80 next edge and state stays RUN. load and start together in IDLE → run starts from load_val.
- Stop: stop at count=0x05 during an up run to 0x20 → IDLE next edge, count=0x05, no done pulse.
- With TFF_SEQ_AUTORELOAD_EN: load_val=0x02, limit=0x04, up → count sequence 2,3,4,2,3,4… with busy held at 1. done pulses on each 4→2 edge.
